// File: rtl/pwm_bank.sv
// pwm_bank: bank of PWM channels sharing one period counter, with shadow
// duty/period registers that reach the comparators only at the period wrap.
module pwm_bank #(
   parameter int CHANNELS = 4,
   parameter int WIDTH = 8,
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
   input  logic                ck,
   input  logic                rst,
   input  logic                duty_we,
   input  logic [CW-1:0]       duty_ch,
   input  logic [WIDTH-1:0]    duty_val,
   input  logic                per_we,
   input  logic [WIDTH-1:0]    per_val,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                cycle_start
);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] per_sh_q, per_sh_d, per_act_q, per_act_d;
   logic [WIDTH-1:0] duty_sh_q [CHANNELS];
   logic [WIDTH-1:0] duty_sh_d [CHANNELS];
   logic [WIDTH-1:0] duty_act_q [CHANNELS];
   logic [WIDTH-1:0] duty_act_d [CHANNELS];
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic cs_q, cs_d, wrap;

   always_comb begin
      wrap = cnt_q == per_act_q;
      cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
      per_sh_d = per_we ? per_val : per_sh_q;
      // actives take the pre-write shadows, so a write on the wrap edge waits a period
      per_act_d = wrap ? per_sh_q : per_act_q;
      cs_d = cnt_q == '0;
      pwm_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         duty_sh_d[i] = (duty_we && duty_ch == CW'(i)) ? duty_val : duty_sh_q[i];
         duty_act_d[i] = wrap ? duty_sh_q[i] : duty_act_q[i];
         pwm_d[i] = cnt_q < duty_act_q[i];
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         cnt_q <= '0;
         per_sh_q <= '1;
         per_act_q <= '1;
         duty_sh_q <= '{default: '0};
         duty_act_q <= '{default: '0};
         pwm_q <= '0;
         cs_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         per_sh_q <= per_sh_d;
         per_act_q <= per_act_d;
         duty_sh_q <= duty_sh_d;
         duty_act_q <= duty_act_d;
         pwm_q <= pwm_d;
         cs_q <= cs_d;
      end
   end

   assign pwm_out = pwm_q;
   assign cycle_start = cs_q;
endmodule
